// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit holding architectural HI/LO.
// Results are computed at issue and committed after a fixed busy latency.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [CW-1:0] cnt;
    logic [31:0]   pend_hi;
    logic [31:0]   pend_lo;

    logic [63:0] sprod;
    logic [63:0] uprod;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] sq;
    logic [31:0] sr;
    logic [31:0] uq;
    logic [31:0] ur;
    logic        bzero;

    always_comb begin
        sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        uprod = {32'd0, a} * {32'd0, b};
        bzero = (b == 32'd0);
        // Signed divide through magnitudes; 0x80000000 survives as its own magnitude.
        abs_a = a[31] ? (~a + 32'd1) : a;
        abs_b = b[31] ? (~b + 32'd1) : b;
        mag_q = bzero ? 32'd0 : abs_a / abs_b;
        mag_r = bzero ? 32'd0 : abs_a % abs_b;
        sq    = (a[31] ^ b[31]) ? (~mag_q + 32'd1) : mag_q;
        sr    = a[31] ? (~mag_r + 32'd1) : mag_r;
        uq    = bzero ? 32'd0 : a / b;
        ur    = bzero ? 32'd0 : a % b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            busy    <= 1'b0;
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else if (busy) begin
            if (cnt == CW'(1)) begin
                hi   <= pend_hi;
                lo   <= pend_lo;
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end else begin
            case (md_op)
                OP_MULT: begin
                    pend_hi <= sprod[63:32];
                    pend_lo <= sprod[31:0];
                    cnt     <= CW'(MULT_CYCLES);
                    busy    <= 1'b1;
                end
                OP_MULTU: begin
                    pend_hi <= uprod[63:32];
                    pend_lo <= uprod[31:0];
                    cnt     <= CW'(MULT_CYCLES);
                    busy    <= 1'b1;
                end
                OP_DIV: begin
                    // Divide by zero recommits the current HI/LO.
                    pend_hi <= bzero ? hi : sr;
                    pend_lo <= bzero ? lo : sq;
                    cnt     <= CW'(DIV_CYCLES);
                    busy    <= 1'b1;
                end
                OP_DIVU: begin
                    pend_hi <= bzero ? hi : ur;
                    pend_lo <= bzero ? lo : uq;
                    cnt     <= CW'(DIV_CYCLES);
                    busy    <= 1'b1;
                end
                OP_MTHI: hi <= a;
                OP_MTLO: lo <= a;
                default: ;
            endcase
        end
    end

endmodule
